// File: rtl/clk_divider_six_pkg.sv
// ============================================================================
// Module : clk_divider_six_pkg
// Brief  : Shared constants and the ratio-legality helper for clk_divider_six.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clk_divider_six_pkg;

  localparam int DEFAULT_DIV_N = 6;

  // Only even ratios can give an exact 50 % duty square wave.
  function automatic bit div_ratio_ok(input int n);
    return (n >= 2) && ((n % 2) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_divider_six_mod_n_counter.sv
// ============================================================================
// Module : clk_divider_six_mod_n_counter
// Brief  : Free-running modulo-N phase counter with a last-phase wrap flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_divider_six_mod_n_counter
  import clk_divider_six_pkg::*;
#(
  parameter int N = DEFAULT_DIV_N,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] C_LAST = W'(N - 1);

  assign wrap = (cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_divider_six.sv
// ============================================================================
// Module : clk_divider_six
// Brief  : Divide-by-DIV_N enable pulse (clk_flag) and 50 % square wave (clk_out).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_divider_six
  import clk_divider_six_pkg::*;
#(
  parameter int DIV_N = DEFAULT_DIV_N,
  parameter int CNT_W = $clog2(DIV_N)
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic clk_flag,
  output logic clk_out
);

  if (!div_ratio_ok(DIV_N)) begin : g_bad_div_n
    $error("clk_divider_six: DIV_N must be even and >= 2");
  end

  if (CNT_W != $clog2(DIV_N)) begin : g_bad_cnt_w
    $error("clk_divider_six: CNT_W is derived from DIV_N and must not be overridden");
  end

  localparam logic [CNT_W-1:0] C_FLAG_PHASE = CNT_W'(DIV_N - 2);
  localparam logic [CNT_W-1:0] C_HALF       = CNT_W'(DIV_N / 2);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [CNT_W-1:0] cnt_next;

  clk_divider_six_mod_n_counter #(
    .N (DIV_N),
    .W (CNT_W)
  ) u_phase (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Outputs are decoded one phase early so the registered values line up with cnt.
  assign cnt_next = wrap ? '0 : (cnt + 1'b1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_flag <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      clk_flag <= (cnt == C_FLAG_PHASE);
      clk_out  <= (cnt_next >= C_HALF);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_divider_six.sv
// ============================================================================
// Module : tb_clk_divider_six
// Brief  : Scoreboard bench for clk_divider_six at DIV_N = 6, 2 and 10.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_divider_six;

  typedef struct {
    int         k;
    logic [2:0] flag;
    logic [2:0] out;
  } exp_t;

  logic sys_clk;
  logic sys_rst_n;
  logic flag6, out6, flag2, out2, flag10, out10;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  clk_divider_six #(.DIV_N(6)) dut6 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_flag(flag6), .clk_out(out6)
  );
  clk_divider_six #(.DIV_N(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_flag(flag2), .clk_out(out2)
  );
  clk_divider_six #(.DIV_N(10)) dut10 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_flag(flag10), .clk_out(out10)
  );

  always #10 sys_clk = ~sys_clk;

  function automatic int div_of(input int i);
    case (i)
      0:       return 6;
      1:       return 2;
      default: return 10;
    endcase
  endfunction

  // k = number of rising edges since release; k = 0 means held in reset.
  function automatic exp_t expect_at(input int k);
    exp_t e;
    e.k    = k;
    e.flag = '0;
    e.out  = '0;
    if (k > 0) begin
      for (int i = 0; i < 3; i++) begin
        int n;
        int ph;
        n  = div_of(i);
        ph = k % n;
        e.flag[i] = (ph == n - 1);
        e.out[i]  = (ph >= n / 2);
      end
    end
    return e;
  endfunction

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge sys_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [2:0] af;
      logic [2:0] ao;
      e  = q.pop_front();
      af = {flag10, flag2, flag6};
      ao = {out10, out2, out6};
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (af[i] !== e.flag[i]) begin
          errors++;
          $display("FAIL clk_flag div=%0d k=%0d got %b want %b", div_of(i), e.k, af[i], e.flag[i]);
        end
        checks++;
        if (ao[i] !== e.out[i]) begin
          errors++;
          $display("FAIL clk_out div=%0d k=%0d got %b want %b", div_of(i), e.k, ao[i], e.out[i]);
        end
      end
    end
  end

  // Rising-edge spacing of the DIV_N = 6 flag: 6 cycles of 20 time units.
  time last_rise;
  bit  have_rise = 1'b0;
  bit  prev6     = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      have_rise = 1'b0;
    end else if (flag6 && !prev6) begin
      if (have_rise) begin
        checks++;
        if ((sys_clk === 1'b0) && ($time - last_rise != 120)) begin
          errors++;
          $display("FAIL flag_period got %0d want 120", $time - last_rise);
        end
      end
      last_rise = $time;
      have_rise = 1'b1;
    end
    prev6 = flag6;
  end

  task automatic push_run(input int n);
    for (int k = 1; k <= n; k++) q.push_back(expect_at(k));
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = budget;
    while (q.size() != 0 && b > 0) begin
      @(negedge sys_clk);
      #1;
      b--;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    sys_clk   = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({flag6, out6, flag2, out2, flag10, out10} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000000", {flag6, out6, flag2, out2, flag10, out10});
    end
    q.push_back(expect_at(0));
    wait_drain(4);
    #4;
    sys_rst_n = 1'b1;
    push_run(600);
    wait_drain(700);

    // Edges 601..605: DIV_N=6 flag is high in this cycle.
    repeat (5) @(posedge sys_clk);
    #2;
    checks++;
    if (flag6 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_flag got %b want 1", flag6);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (flag6 !== 1'b0 || out6 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_clear got flag=%b out=%b want flag=0 out=0", flag6, out6);
    end
    q.push_back(expect_at(0));
    wait_drain(4);
    #4;
    sys_rst_n = 1'b1;
    push_run(60);
    wait_drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
